// File: rtl/input_debouncer.sv
// Per-channel input conditioning: synchroniser, consecutive-sample debounce FSM,
// clean level plus one-cycle rise/fall pulses and a registered OR of the rises.

module input_debouncer_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_nxt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   level_nxt, fall_nxt;

  // Only the last synchroniser stage is allowed to reach the FSM.
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      state  <= STABLE_LOW;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      level  <= level_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s) begin
          state_nxt = CHECK_HIGH;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHECK_HIGH: begin
        if (!s) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_nxt = CHECK_LOW;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      CHECK_LOW: begin
        if (s) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end
endmodule

module input_debouncer #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_rise
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("input_debouncer: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
    $error("input_debouncer: DEBOUNCE_CYCLES must be 2..65535");
  end

  logic [WIDTH-1:0] rise_nxt;

  input_debouncer_lane #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lane [WIDTH-1:0] (
    .clk     (clk),
    .rst     (rst),
    .raw     (raw_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .rise_nxt(rise_nxt)
  );

  // Built from the lanes' next-state pulses so it lines up with rise exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) any_rise <= 1'b0;
    else      any_rise <= |rise_nxt;
  end
endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboarded random/directed bench for input_debouncer using a run-length
// reference model fed through an ideal SYNC_STAGES-deep delay line.

module tb_input_debouncer;
  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] level, rise, fall;
  logic         any_rise;

  always #5 clk = ~clk;

  input_debouncer #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .raw_in  (raw_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .any_rise(any_rise)
  );

  typedef struct packed {
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any_rise;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: a change commits once D consecutive delayed samples differ from the level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_level;
  logic [W-1:0] m_s;
  int           run[W];
  exp_t         m_e;

  always @(posedge clk) begin
    m_e = '0;
    if (!rst) begin
      hist = {};
      for (int k = 0; k < S; k++) hist.push_back('0);
      m_level = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      m_s = hist.pop_front();
      hist.push_back(raw_in);
      for (int i = 0; i < W; i++) begin
        if (m_s[i] != m_level[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == D) begin
            m_level[i] = m_s[i];
            run[i]     = 0;
            if (m_s[i]) m_e.rise[i] = 1'b1;
            else        m_e.fall[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_e.level    = m_level;
      m_e.any_rise = |m_e.rise;
    end
    exp_q.push_back(m_e);
  end

  // Monitor: compares every cycle; asynchronous reset forces an all-zero expectation.
  exp_t mon_e;
  exp_t mon_got;
  int   rise_cnt[W];
  int   fall_cnt[W];
  initial for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end

  always @(negedge clk) begin
    mon_got = {level, rise, fall, any_rise};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty t=%0t got=%h", $time, mon_got);
    end else begin
      mon_e = exp_q.pop_front();
      if (!rst) mon_e = '0;
      if (mon_got !== mon_e) begin
        fails++;
        $display("FAIL outputs t=%0t got lvl=%h rise=%h fall=%h any=%b want lvl=%h rise=%h fall=%h any=%b",
                 $time, level, rise, fall, any_rise,
                 mon_e.level, mon_e.rise, mon_e.fall, mon_e.any_rise);
      end
    end
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] += int'(rise[i]);
      fall_cnt[i] += int'(fall[i]);
    end
  end

  int r0[W];
  int f0[W];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    @(negedge clk); #1;
    for (int i = 0; i < W; i++) begin r0[i] = rise_cnt[i]; f0[i] = fall_cnt[i]; end
    tick(1);
  endtask

  task automatic chk_pulses(input string name, input int ch, input int exp_r, input int exp_f);
    @(negedge clk); #1;
    tests++;
    if (rise_cnt[ch] - r0[ch] != exp_r || fall_cnt[ch] - f0[ch] != exp_f) begin
      fails++;
      $display("FAIL %s ch%0d got rises=%0d falls=%0d want rises=%0d falls=%0d", name, ch,
               rise_cnt[ch] - r0[ch], fall_cnt[ch] - f0[ch], exp_r, exp_f);
    end
  endtask

  task automatic chk_level(input string name, input logic [W-1:0] want);
    tests++;
    if (level !== want) begin
      fails++;
      $display("FAIL %s level got=%h want=%h", name, level, want);
    end
  endtask

  int           hold[W];
  logic [W-1:0] bounce_seq;

  initial begin
    // Reset with all inputs high, then release: all channels commit together.
    rst = 1'b0; raw_in = 4'hF;
    tick(3);
    chk_level("reset_hold", 4'h0);
    snap();
    rst = 1'b1;
    tick(9);
    for (int i = 0; i < W; i++) chk_pulses("reset_release", i, 1, 0);
    chk_level("reset_release_lvl", 4'hF);
    raw_in = 4'h0; tick(9);

    // Clean step on channel 0.
    snap();
    raw_in = 4'h1; tick(9);
    chk_level("clean_step", 4'h1);
    raw_in = 4'h0; tick(9);
    chk_pulses("clean_step", 0, 1, 1);
    chk_pulses("clean_step_other", 1, 0, 0);

    // Glitch of 3 cycles rejected, 4-cycle pulse commits both edges.
    snap();
    raw_in = 4'h2; tick(3);
    raw_in = 4'h0; tick(9);
    chk_pulses("glitch3", 1, 0, 0);
    snap();
    raw_in = 4'h2; tick(4);
    raw_in = 4'h0; tick(10);
    chk_pulses("pulse4", 1, 1, 1);

    // Bounce on channel 2, then hold.
    snap();
    bounce_seq = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      raw_in = ((6'b101101 >> (5 - k)) & 1) != 0 ? 4'h4 : 4'h0;
      tick(1);
    end
    raw_in = 4'h4; tick(10);
    chk_pulses("bounce", 2, 1, 0);
    raw_in = 4'h0; tick(9);

    // Reset asserted mid-check on channel 3.
    snap();
    raw_in = 4'h8; tick(4);
    rst = 1'b0; #2;
    chk_level("mid_reset", 4'h0);
    tick(1);
    rst = 1'b1; tick(9);
    chk_pulses("mid_reset_refire", 3, 1, 0);
    raw_in = 4'h0; tick(9);

    // Simultaneous channels.
    snap();
    raw_in = 4'h5; tick(9);
    chk_level("multi_rise", 4'h5);
    raw_in = 4'h0; tick(9);
    chk_pulses("multi_ch0", 0, 1, 1);
    chk_pulses("multi_ch2", 2, 1, 1);
    chk_pulses("multi_ch1", 1, 0, 0);

    // Random bouncing channels with occasional resets.
    for (int i = 0; i < W; i++) hold[i] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        hold[i]--;
        if (hold[i] == 0) begin
          raw_in[i] = ~raw_in[i];
          hold[i]   = int'($urandom_range(1, 8));
        end
      end
      if ($urandom_range(0, 399) == 0) rst = 1'b0;
      else rst = 1'b1;
      tick(1);
    end
    rst = 1'b1;
    tick(3);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Per-channel input conditioning stage that sits directly upstream of the flip-flop cells.
- Takes raw asynchronous inputs such as push-buttons and switches, and synchronises them into the clk domain.
- Debounces each channel with a consecutive-sample counter.
- Produces a clean level plus single-cycle rise/fall pulses. These pulses drive the t/j/k/s/r/d inputs of the downstream flip-flops without glitches or metastability.

Parameters:
- WIDTH, 4, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to commit a change; legal range 2..65535; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low. Assertion acts immediately; release is synchronous to clk by system design.
- raw_in  input  WIDTH  raw asynchronous inputs, one bit per channel.
- level  output  WIDTH  debounced level per channel.
- rise  output  WIDTH  one-cycle pulse per channel on a committed 0->1 change.
- fall  output  WIDTH  one-cycle pulse per channel on a committed 1->0 change.
- any_rise  output  1  OR of all rise bits, registered in the same cycle as rise.

Behaviour:
- Reset (rst=0):
  - All synchroniser flops = 0.
  - level = 0, rise = 0, fall = 0, any_rise = 0.
  - Every channel FSM = STABLE_LOW, every counter = 0.
  - Takes effect asynchronously, including mid-check. No pulse is emitted as a result of reset or its release.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops to give s[i]. Only s[i] is used downstream; raw_in never feeds logic directly.
- Per-channel FSM states and counter:
  - States: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
  - Counter width is clog2(DEBOUNCE_CYCLES); it saturates only by commit.
- STABLE_LOW:
  - s=1 -> CHECK_HIGH, cnt=1.
  - s=0 -> stay, cnt=0.
- CHECK_HIGH:
  - s=0 -> STABLE_LOW, cnt=0 (glitch rejected, no pulse).
  - s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1.
  - s=1 and cnt=DEBOUNCE_CYCLES-1 -> STABLE_HIGH, cnt=0, level<=1, rise<=1.
- STABLE_HIGH and CHECK_LOW: mirror image of the above, with fall in place of rise and level<=0 on commit.
- level is a registered output equal to 1 in STABLE_HIGH and CHECK_LOW; it holds its old value throughout the check states.
- rise and fall are registered and high for exactly one cycle after the commit edge, then return to 0. rise[i] and fall[i] are never high together.
- Latency:
  - A raw step held stable, sampled at edge 1, commits at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - With defaults this is 6 edges: level and the pulse are visible after edge 6.
- Bounce: any return of s to the committed level before the count completes restarts the count from zero on the next departure.
- Channels are fully independent. Simultaneous commits on several channels produce simultaneous pulses; any_rise=1 if at least one rise bit is set.
- A raw pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes level or produces a pulse.
- The block has no enable or clock gating; it runs every cycle.

Test Plan:
- Reset check: hold rst=0 with raw_in=4'hF -> level=0, rise=0, fall=0, any_rise=0; after release, level[3:0] goes to 1 at edge 6 with rise=4'hF for one cycle and any_rise=1.
- Clean step: defaults, raw_in[0] 0->1 before edge 1 and held -> level[0]=1 and rise[0]=1 after edge 6; rise[0]=0 after edge 7; other channels unchanged.
- Glitch rejection: raw_in[1]=1 for exactly 3 cycles, then 0 -> level[1] stays 0 and rise[1] never asserts; a 4-cycle pulse commits rise, then commits fall 4 edges after s returns to 0.
- Bounce: raw_in[2] toggles 1,0,1,1,0,1 on successive cycles, then holds 1 -> exactly one rise[2] pulse, occurring 6 edges after the final 0->1 transition.
- Reset mid-check: raw_in[3] goes high; at edge 4 (CHECK_HIGH, cnt=2) assert rst=0 -> level, rise and counters clear immediately; after release with raw still 1, rise[3] fires 6 edges later.
- Multi-channel: raw_in 4'h0->4'h5 together, then 4'h5->4'h0 after level settles -> rise=4'h5 for one cycle with any_rise=1; later fall=4'h5 for one cycle with any_rise=0.
